// File: rtl/calc_pkg.sv
// Shared definitions for the parametrised calculator.
//   state_e : top-level FSM state; its encoding is also the status output code.
//   phase_e : sub-phase of OCUPADA (arithmetic, then binary-to-BCD conversion).
//   CMD_*   : keypad command codes above the digits 0-9.
//   pow10   : elaboration-time helper used to derive the operand limits.
package calc_pkg;

  typedef enum logic [1:0] {
    ERRO    = 2'd0,
    PRONTA  = 2'd1,
    OCUPADA = 2'd2
  } state_e;

  typedef enum logic {
    COMPUTE = 1'b0,
    CONVERT = 1'b1
  } phase_e;

  localparam logic [3:0] CMD_ADD = 4'd10;
  localparam logic [3:0] CMD_SUB = 4'd11;
  localparam logic [3:0] CMD_MUL = 4'd12;
  localparam logic [3:0] CMD_DIV = 4'd13;
  localparam logic [3:0] CMD_EQ  = 4'd14;
  localparam logic [3:0] CMD_CLR = 4'd15;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/calculadora_param_if.sv
// Keypad-side and display-side signals of the calculator.
//   cmd[3:0], cmd_valid : command from the keypad decoder
//   status[1:0]         : 0 ERRO, 1 PRONTA, 2 OCUPADA
//   pos[3:0], dig[3:0]  : display position being driven and its BCD digit
// Handshake: cmd is consumed on every rising edge where cmd_valid is high and
// the calculator can take it (any command in PRONTA, only CMD_CLR in ERRO).
// There is no ready; commands offered at other times are dropped, and the
// producer can watch status to know when entry is possible.
interface calculadora_param_if;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic [1:0] status;
  logic [3:0] pos;
  logic [3:0] dig;

  modport master (output cmd, cmd_valid, input status, pos, dig);
  modport slave  (input cmd, cmd_valid, output status, pos, dig);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to BCD converter.
//   clock, reset : system clock, synchronous active-high reset
//   start        : load bin and begin; the first shift happens on this edge
//   bin          : binary value to convert
//   busy         : conversion in progress
//   done         : one-cycle pulse, asserted W cycles after start was asserted
//   bcd          : result, valid while done is high and held afterwards
module bin2bcd_seq #(
  parameter int W        = 32,
  parameter int N_DIGITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*N_DIGITS-1:0] bcd
);
  localparam int BW = 4 * N_DIGITS;
  localparam int CW = $clog2(W) + 1;

  logic [W-1:0]  sr;
  logic [CW-1:0] cnt;
  logic [BW-1:0] adj;

  // Add 3 to every nibble >= 5 before the shift so it carries correctly.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sr   <= '0;
      cnt  <= '0;
      bcd  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // The first step acts on an all-zero BCD value, so no adjust is needed.
        bcd  <= BW'(bin[W-1]);
        sr   <= bin << 1;
        cnt  <= CW'(1);
        busy <= 1'b1;
      end else if (busy) begin
        bcd <= (adj << 1) | BW'(sr[W-1]);
        sr  <= sr << 1;
        cnt <= cnt + CW'(1);
        if (cnt == CW'(W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/calculadora_param.sv
// Parametrised four-function calculator between keypad decoder and
// 7-segment scan driver.
//   clock, reset : system clock, synchronous active-high reset
//   bus          : slave side of calculadora_param_if (cmd, cmd_valid in;
//                  status, pos, dig out). status is the FSM state itself.
// Operands are kept both in binary (reg1/reg2) and in a BCD display buffer.
// Multiply is shift-add and divide is restoring, W steps each; results are
// converted back to BCD by bin2bcd_seq before returning to PRONTA.
module calculadora_param #(
  parameter int N_DIGITS = 8,
  parameter int W        = 32
) (
  input logic           clock,
  input logic           reset,
  calculadora_param_if.slave bus
);
  import calc_pkg::*;

  localparam int BW = 4 * N_DIGITS;
  localparam int CW = $clog2(W) + 1;
  localparam logic [W-1:0] MAX  = W'(pow10(N_DIGITS) - 64'd1);
  // An operand at or above this already has N_DIGITS digits.
  localparam logic [W-1:0] FULL = W'(pow10(N_DIGITS - 1));

  state_e        state;
  phase_e        phase;
  logic [W-1:0]  reg1, reg2;
  logic [BW-1:0] bcd_buf;
  logic [3:0]    op;
  logic          set_op, res_flag;
  logic [3:0]    pos, dig_q;
  logic [CW-1:0] cnt;
  logic [2*W-1:0] acc, mcand;
  logic [W-1:0]  mplier, rem, quo;

  logic [W-1:0]  operand, operand_nx;
  logic          digit_ok;
  logic [BW-1:0] entry_buf;
  logic [3:0]    pos_nx;
  logic [2*W-1:0] acc_nx, res_wide;
  logic [W:0]    trial;
  logic [W-1:0]  rem_nx, quo_nx;
  logic          comp_last, err;
  logic          conv_start, conv_busy, conv_done;
  logic [BW-1:0] conv_bcd;

  // Digit entry: a pending result is discarded before the first new digit.
  always_comb begin
    operand    = set_op ? reg2 : (res_flag ? '0 : reg1);
    digit_ok   = operand < FULL;
    operand_nx = operand * W'(10) + W'(bus.cmd);
    entry_buf  = res_flag ? '0 : bcd_buf;
    pos_nx     = (pos == 4'(N_DIGITS - 1)) ? 4'd0 : pos + 4'd1;
  end

  // One arithmetic step per cycle. On the last step the final result is taken
  // from the next-state value so the error check and conversion start without
  // an extra cycle.
  always_comb begin
    acc_nx = mplier[0] ? acc + mcand : acc;
    trial  = {rem, quo[W-1]};
    if (trial >= {1'b0, reg2}) begin
      rem_nx = W'(trial - {1'b0, reg2});
      quo_nx = {quo[W-2:0], 1'b1};
    end else begin
      rem_nx = trial[W-1:0];
      quo_nx = {quo[W-2:0], 1'b0};
    end
    comp_last = 1'b1;
    err       = 1'b0;
    case (op)
      CMD_SUB: begin
        res_wide = (2*W)'(reg1 - reg2);
        err      = reg2 > reg1;
      end
      CMD_MUL: begin
        res_wide  = acc_nx;
        comp_last = cnt == CW'(W - 1);
      end
      CMD_DIV: begin
        res_wide  = (2*W)'(quo_nx);
        comp_last = cnt == CW'(W - 1);
        err       = reg2 == '0;
      end
      default: res_wide = (2*W)'(reg1) + (2*W)'(reg2);
    endcase
    if (res_wide > (2*W)'(MAX)) err = 1'b1;
    conv_start = (state == OCUPADA) && (phase == COMPUTE) && comp_last &&
                 !err && !conv_busy;
  end

  bin2bcd_seq #(.W(W), .N_DIGITS(N_DIGITS)) u_conv (
    .clock (clock),
    .reset (reset),
    .start (conv_start),
    .bin   (res_wide[W-1:0]),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= PRONTA;
      phase    <= COMPUTE;
      reg1     <= '0;
      reg2     <= '0;
      bcd_buf  <= '0;
      op       <= CMD_ADD;
      set_op   <= 1'b0;
      res_flag <= 1'b0;
      pos      <= '0;
      dig_q    <= '0;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      rem      <= '0;
      quo      <= '0;
    end else begin
      // Scanning freezes while busy so the display holds its last digit.
      if (state != OCUPADA) begin
        pos   <= pos_nx;
        dig_q <= bcd_buf[4*pos_nx +: 4];
      end
      case (state)
        PRONTA: begin
          if (bus.cmd_valid) begin
            if (bus.cmd <= 4'd9) begin
              if (digit_ok) begin
                if (set_op) reg2 <= operand_nx;
                else        reg1 <= operand_nx;
                bcd_buf  <= (entry_buf << 4) | BW'(bus.cmd);
                res_flag <= 1'b0;
              end
            end else if (bus.cmd == CMD_EQ) begin
              if (set_op) begin
                state  <= OCUPADA;
                phase  <= COMPUTE;
                cnt    <= '0;
                acc    <= '0;
                mcand  <= (2*W)'(reg1);
                mplier <= reg2;
                rem    <= '0;
                quo    <= reg1;
              end
            end else if (bus.cmd == CMD_CLR) begin
              if (set_op) reg2 <= reg2 / W'(10);
              else        reg1 <= reg1 / W'(10);
              bcd_buf <= bcd_buf >> 4;
            end else begin
              op       <= bus.cmd;
              set_op   <= 1'b1;
              res_flag <= 1'b0;
            end
          end
        end
        OCUPADA: begin
          if (phase == COMPUTE) begin
            if (comp_last) begin
              if (err) begin
                state <= ERRO;
              end else begin
                phase  <= CONVERT;
                reg1   <= res_wide[W-1:0];
                reg2   <= '0;
                set_op <= 1'b0;
              end
            end else begin
              cnt    <= cnt + CW'(1);
              acc    <= acc_nx;
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
              rem    <= rem_nx;
              quo    <= quo_nx;
            end
          end else if (conv_done) begin
            state    <= PRONTA;
            phase    <= COMPUTE;
            res_flag <= 1'b1;
            bcd_buf  <= conv_bcd;
          end
        end
        ERRO: begin
          if (bus.cmd_valid && bus.cmd == CMD_CLR) begin
            state    <= PRONTA;
            phase    <= COMPUTE;
            reg1     <= '0;
            reg2     <= '0;
            bcd_buf  <= '0;
            op       <= CMD_ADD;
            set_op   <= 1'b0;
            res_flag <= 1'b0;
            dig_q    <= '0;
            cnt      <= '0;
          end
        end
        default: state <= PRONTA;
      endcase
    end
  end

  assign bus.status = state;
  assign bus.pos    = pos;
  assign bus.dig    = (state == ERRO) ? 4'hE : dig_q;
endmodule
